// File: rtl/load_store_unit_if.sv
// Data-port bus between the load/store unit and the unified word-addressed RAM.
// master : load/store unit (drives address, write data, enables; reads data)
// slave  : RAM (combinational read of the word at ram_addr, write on clock edge)
//   ram_addr  [ADDR_W-1:0]  word-aligned byte address
//   ram_wdata [31:0]        full word to write
//   ram_we                  write enable
//   ram_re                  read enable
//   ram_rdata [31:0]        word read from ram_addr
interface load_store_unit_if #(parameter int ADDR_W = 12);
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;

  modport master (
    output ram_addr, ram_wdata, ram_we, ram_re,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_we, ram_re,
    output ram_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and the RAM data port.
// Accepts one memory op per instruction, does byte/halfword extraction with
// sign/zero extension, sub-word stores by read-modify-write, and rejects
// misaligned or out-of-range accesses. Holds the PC (stall) while busy.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   CUOp[5:0]       control-unit op (LB=10 LH=11 LW=12 LBU=13 LHU=14 SB=15 SH=16 SW=17)
//   addr[31:0]      effective byte address
//   store_data[31:0] rs2 value
//   ram             RAM data-port bus (master side)
//   load_data[31:0] extended load result, zero unless load_valid
//   load_valid      one-cycle load result strobe
//   mem_err         one-cycle misaligned/out-of-range pulse
//   stall           hold PC/writeback while high
//
// state | meaning
// IDLE  | waiting for a memory op; accepts and latches it
// READ  | read the containing word into word_q
// WRITE | write full word (SW) or merged word (SB/SH)
// DONE  | present load result or error; PC advances at end
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          CUOp,
  input  logic [31:0]         addr,
  input  logic [31:0]         store_data,
  load_store_unit_if.master   ram,
  output logic [31:0]         load_data,
  output logic                load_valid,
  output logic                mem_err,
  output logic                stall
);

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       word_q;
  logic              err_q;

  logic        is_mem;
  logic        acc_err;
  logic        op_is_load;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;
  logic [31:0] merged;

  assign is_mem = (CUOp >= OP_LB) && (CUOp <= OP_SW);

  // Alignment and range check on the incoming address, evaluated at acceptance.
  always_comb begin
    acc_err = (addr[31:ADDR_W] != '0);
    if ((CUOp == OP_LH || CUOp == OP_LHU || CUOp == OP_SH) && addr[0])
      acc_err = 1'b1;
    if ((CUOp == OP_LW || CUOp == OP_SW) && (addr[1:0] != 2'b00))
      acc_err = 1'b1;
  end

  assign op_is_load = (op_q >= OP_LB) && (op_q <= OP_LHU);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && is_mem) begin
        op_q   <= CUOp;
        addr_q <= addr[ADDR_W-1:0];
        data_q <= store_data;
        err_q  <= acc_err;
      end
      if (state_q == READ)
        word_q <= ram.ram_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (is_mem) begin
          if (acc_err)           state_d = DONE;
          else if (CUOp == OP_SW) state_d = WRITE;
          else                   state_d = READ;
        end
      end
      READ:    state_d = op_is_load ? DONE : WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction and merge both work on the captured word.
  always_comb begin
    byte_sel = 8'h00;
    unique case (addr_q[1:0])
      2'd0: byte_sel = word_q[7:0];
      2'd1: byte_sel = word_q[15:8];
      2'd2: byte_sel = word_q[23:16];
      2'd3: byte_sel = word_q[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];

    ext_data = word_q;
    unique case (op_q)
      OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_data = {24'h0, byte_sel};
      OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_data = {16'h0, half_sel};
      default: ext_data = word_q;
    endcase

    merged = word_q;
    if (op_q == OP_SW) begin
      merged = data_q;
    end else if (op_q == OP_SB) begin
      unique case (addr_q[1:0])
        2'd0: merged[7:0]   = data_q[7:0];
        2'd1: merged[15:8]  = data_q[7:0];
        2'd2: merged[23:16] = data_q[7:0];
        2'd3: merged[31:24] = data_q[7:0];
        default: merged = word_q;
      endcase
    end else if (op_q == OP_SH) begin
      if (addr_q[1]) merged[31:16] = data_q[15:0];
      else           merged[15:0]  = data_q[15:0];
    end
  end

  always_comb begin
    ram.ram_addr  = '0;
    ram.ram_wdata = '0;
    ram.ram_we    = 1'b0;
    ram.ram_re    = 1'b0;
    load_data     = '0;
    load_valid    = 1'b0;
    mem_err       = 1'b0;
    stall         = 1'b0;
    unique case (state_q)
      IDLE: stall = is_mem;
      READ: begin
        stall        = 1'b1;
        ram.ram_re   = 1'b1;
        ram.ram_addr = {addr_q[ADDR_W-1:2], 2'b00};
      end
      WRITE: begin
        stall         = 1'b1;
        ram.ram_we    = 1'b1;
        ram.ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        ram.ram_wdata = merged;
      end
      DONE: begin
        mem_err = err_q;
        if (op_is_load && !err_q) begin
          load_valid = 1'b1;
          load_data  = ext_data;
        end
      end
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int ADDR_W = 12;
  localparam logic [5:0] LB = 6'd10, LH = 6'd11, LW = 6'd12, LBU = 6'd13,
                         LHU = 6'd14, SB = 6'd15, SH = 6'd16, SW = 6'd17, ADD = 6'd28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  CUOp;
  logic [31:0] addr, store_data, load_data;
  logic        load_valid, mem_err, stall;

  load_store_unit_if #(.ADDR_W(ADDR_W)) ram_bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .CUOp(CUOp), .addr(addr), .store_data(store_data),
    .ram(ram_bus), .load_data(load_data), .load_valid(load_valid),
    .mem_err(mem_err), .stall(stall)
  );

  always #5 clk = ~clk;

  // RAM model with a bench-side preload port
  logic [31:0] mem [0:1023];
  logic        pl_we = 1'b0;
  int          pl_idx = 0;
  logic [31:0] pl_val = '0;
  assign ram_bus.ram_rdata = mem[ram_bus.ram_addr[ADDR_W-1:2]];
  always @(posedge clk) begin
    if (ram_bus.ram_we) mem[ram_bus.ram_addr[ADDR_W-1:2]] <= ram_bus.ram_wdata;
    else if (pl_we)     mem[pl_idx] <= pl_val;
  end

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int we_total = 0;

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (ram_bus.ram_we && ram_bus.ram_re) begin
      n_err++;
      $display("FAIL we_re_exclusive: we=%0b re=%0b, required not both high", ram_bus.ram_we, ram_bus.ram_re);
    end
    if (!load_valid) begin
      n_cmp++;
      if (load_data != 32'h0) begin
        n_err++;
        $display("FAIL load_data_zero: got %h, required 00000000 when load_valid=0", load_data);
      end
    end
    if (load_valid || mem_err) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_resp: load_valid=%0b mem_err=%0b data=%h, none required", load_valid, mem_err, load_data);
      end else begin
        e = q.pop_front();
        if (e.is_err != mem_err || e.is_err == load_valid || (!e.is_err && load_data != e.data)) begin
          n_err++;
          $display("FAIL resp: got err=%0b valid=%0b data=%h, required err=%0b data=%h",
                   mem_err, load_valid, load_data, e.is_err, e.data);
        end
      end
    end
    if (ram_bus.ram_we) we_total++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pl_idx = idx; pl_val = v; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Issue one op; counts stall cycles and write cycles (cycle index of first write).
  task automatic issue(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d, input int exp_stall, input int exp_we_cyc,
                       input logic push, input logic is_err, input logic [31:0] exp_data);
    int stall_cnt, we_cnt, we_cyc, cyc;
    logic done;
    exp_t e;
    if (push) begin
      e.is_err = is_err; e.data = exp_data;
      q.push_back(e);
    end
    stall_cnt = 0; we_cnt = 0; we_cyc = -1; done = 1'b0;
    @(posedge clk); #1;
    CUOp = op; addr = a; store_data = d;
    @(negedge clk);
    if (stall) stall_cnt++;
    if (ram_bus.ram_we) begin we_cnt++; we_cyc = 0; end
    @(posedge clk); #1;
    CUOp = 6'd0; addr = 32'hFFFF_FFFF; store_data = 32'h0BAD_F00D;
    for (cyc = 1; cyc < 8 && !done; cyc++) begin
      @(negedge clk);
      if (ram_bus.ram_we) begin we_cnt++; if (we_cyc < 0) we_cyc = cyc; end
      if (stall) stall_cnt++;
      else done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: stall still high after 8 cycles, required release", name);
    end
    check({name, "_stall_cycles"}, stall_cnt, exp_stall);
    check({name, "_we_cycles"}, we_cnt, (exp_we_cyc < 0) ? 0 : 1);
    check({name, "_we_cycle_idx"}, we_cyc, exp_we_cyc);
  endtask

  initial begin
    int we_before;
    CUOp = 6'd0; addr = 32'h0; store_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {load_data | ram_bus.ram_wdata}, 32'h0);
    check("reset_ctrl", {24'h0, load_valid, mem_err, ram_bus.ram_we, ram_bus.ram_re, stall, 3'b0}, 32'h0);
    check("reset_addr", {20'h0, ram_bus.ram_addr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    preload(0,  32'hCAFE_F00D);
    preload(4,  32'h0000_0000);
    preload(8,  32'h80FF_7F01);
    preload(12, 32'h1122_3344);
    preload(13, 32'h5A5A_5A5A);
    preload(16, 32'h5566_7788);

    // Word store then load
    issue("sw_010", SW, 32'h010, 32'hDEAD_BEEF, 2, 1, 1'b0, 1'b0, 32'h0);
    check("mem_010", mem[4], 32'hDEAD_BEEF);
    issue("lw_010", LW, 32'h010, 32'h0, 2, -1, 1'b1, 1'b0, 32'hDEAD_BEEF);

    // Byte/half extraction from 0x80FF7F01
    issue("lb_023",  LB,  32'h023, 32'h0, 2, -1, 1'b1, 1'b0, 32'hFFFF_FF80);
    issue("lbu_023", LBU, 32'h023, 32'h0, 2, -1, 1'b1, 1'b0, 32'h0000_0080);
    issue("lb_020",  LB,  32'h020, 32'h0, 2, -1, 1'b1, 1'b0, 32'h0000_0001);
    issue("lb_021",  LB,  32'h021, 32'h0, 2, -1, 1'b1, 1'b0, 32'h0000_007F);
    issue("lbu_022", LBU, 32'h022, 32'h0, 2, -1, 1'b1, 1'b0, 32'h0000_00FF);
    issue("lh_022",  LH,  32'h022, 32'h0, 2, -1, 1'b1, 1'b0, 32'hFFFF_80FF);
    issue("lh_020",  LH,  32'h020, 32'h0, 2, -1, 1'b1, 1'b0, 32'h0000_7F01);
    issue("lhu_020", LHU, 32'h020, 32'h0, 2, -1, 1'b1, 1'b0, 32'h0000_7F01);
    issue("lhu_022", LHU, 32'h022, 32'h0, 2, -1, 1'b1, 1'b0, 32'h0000_80FF);

    // Sub-word read-modify-write
    issue("sb_031", SB, 32'h031, 32'hFFFF_FFAA, 3, 2, 1'b0, 1'b0, 32'h0);
    check("mem_030_sb", mem[12], 32'h1122_AA44);
    issue("sh_032", SH, 32'h032, 32'h7777_BEEF, 3, 2, 1'b0, 1'b0, 32'h0);
    check("mem_030_sh", mem[12], 32'hBEEF_AA44);
    issue("lw_030", LW, 32'h030, 32'h0, 2, -1, 1'b1, 1'b0, 32'hBEEF_AA44);

    // Errors
    we_before = we_total;
    issue("err_lw_012",  LW, 32'h012,  32'h0,         1, -1, 1'b1, 1'b1, 32'h0);
    check("mem_010_err", mem[4], 32'hDEAD_BEEF);
    issue("err_sh_035",  SH, 32'h035,  32'h1234_5678, 1, -1, 1'b1, 1'b1, 32'h0);
    check("mem_034_err", mem[13], 32'h5A5A_5A5A);
    issue("err_sw_1000", SW, 32'h1000, 32'h1234_5678, 1, -1, 1'b1, 1'b1, 32'h0);
    check("mem_000_err", mem[0], 32'hCAFE_F00D);
    check("err_no_writes", we_total - we_before, 0);

    // Reset during READ of an SB
    we_before = we_total;
    @(posedge clk); #1;
    CUOp = SB; addr = 32'h041; store_data = 32'h0000_00EE;
    @(posedge clk); #1;
    CUOp = 6'd0; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_read", {31'h0, ram_bus.ram_re}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {load_data | ram_bus.ram_wdata}, 32'h0);
    check("rst_mid_ctrl", {27'h0, load_valid, mem_err, ram_bus.ram_we, ram_bus.ram_re, stall}, 32'h0);
    check("rst_mid_addr", {20'h0, ram_bus.ram_addr}, 32'h0);
    repeat (4) @(negedge clk);
    check("rst_mid_no_write", we_total - we_before, 0);
    check("mem_040_rst", mem[16], 32'h5566_7788);

    // Non-memory op held
    @(posedge clk); #1;
    CUOp = ADD; addr = 32'h010; store_data = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("nonmem_ctrl", {28'h0, stall, ram_bus.ram_re, ram_bus.ram_we, load_valid}, 32'h0);
    end
    @(posedge clk); #1;
    CUOp = 6'd0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
